imm_field_packer: RTL and testbench

Pipelined immediate-field packer: the encode direction of the processor's immediate sign extender. It accepts a 32-bit signed value plus the same 2-bit field selector the extender uses, and emits the N-bit field (N = 26, 14 or 17) that the extender expands back to the original value, flagging values that do not fit. It sits in the instruction-assembly and loader path that writes instruction memory, with valid/ready handshakes on both sides and a running error counter.

---
 rtl/imm_field_packer_if.sv | 29 ++
 rtl/imm_field_packer.sv | 168 ++++++++++++++++
 tb/tb_imm_field_packer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_field_packer_if.sv
// imm_field_packer_if: input/output handshake bundle of the immediate-field packer.
interface imm_field_packer_if;
    localparam int unsigned VALUE_W = 32;
    localparam int unsigned FIELD_W = 26;
    localparam int unsigned SEL_W   = 2;

    logic               in_valid;
    logic               in_ready;
    logic [VALUE_W-1:0] in_value;
    logic [SEL_W-1:0]   in_select;
    logic               out_valid;
    logic               out_ready;
    logic [FIELD_W-1:0] out_field;
    logic [SEL_W-1:0]   out_select;
    logic               out_overflow;
    logic               out_invalid;

    // Producer of words / consumer of results.
    modport master (
        output in_valid, in_value, in_select, out_ready,
        input  in_ready, out_valid, out_field, out_select, out_overflow, out_invalid
    );

    // The packer itself.
    modport slave (
        input  in_valid, in_value, in_select, out_ready,
        output in_ready, out_valid, out_field, out_select, out_overflow, out_invalid
    );
endinterface

// File: rtl/imm_field_packer.sv
// imm_field_packer: two-stage encoder from a 32-bit signed value to the
// 26/14/17-bit immediate field the sign extender expands back, with overflow
// flagging and a saturating error counter.
// Optional feature macro: IMM_PACK_SATURATE_EN (clamp out-of-range values
// instead of truncating them).
module imm_field_packer (
    input  logic                clock,
    input  logic                reset,
    imm_field_packer_if.slave   bus,
    input  logic                err_clear,
    output logic [15:0]         err_count,
    output logic                err_sticky
);
    localparam int unsigned VALUE_W = 32;
    localparam int unsigned FIELD_W = 26;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned NW_W    = 5;

    // Stage 1: accepted input word
    logic               s1_valid_q,  s1_valid_d;
    logic [VALUE_W-1:0] s1_value_q,  s1_value_d;
    logic [SEL_W-1:0]   s1_select_q, s1_select_d;

    // Stage 2: computed result, drives the output side
    logic               s2_valid_q,    s2_valid_d;
    logic [FIELD_W-1:0] s2_field_q,    s2_field_d;
    logic [SEL_W-1:0]   s2_select_q,   s2_select_d;
    logic               s2_overflow_q, s2_overflow_d;
    logic               s2_invalid_q,  s2_invalid_d;

    // Error accounting
    logic [CNT_W-1:0]   err_count_q,  err_count_d;
    logic               err_sticky_q, err_sticky_d;

    // Handshake and datapath intermediates
    logic               in_ready_c;
    logic               in_fire_c;
    logic               s1_adv_c;
    logic               out_fire_c;
    logic [NW_W-1:0]    field_w_c;
    logic [VALUE_W-1:0] shifted_c;
    logic [VALUE_W-1:0] mask_c;
    logic [VALUE_W-1:0] half_c;
    logic               fits_c;
    logic [FIELD_W-1:0] calc_field_c;
    logic               calc_overflow_c;
    logic               calc_invalid_c;

    // Pipeline flow control: S1 moves on whenever S2 is empty or draining.
    always_comb begin
        out_fire_c = s2_valid_q && bus.out_ready;
        s1_adv_c   = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready_c = !s1_valid_q || !s2_valid_q || bus.out_ready;
        in_fire_c  = bus.in_valid && in_ready_c;
    end

    // Encode the S1 word: fit test via arithmetic shift, then truncate or clamp.
    always_comb begin
        calc_field_c    = '0;
        calc_overflow_c = 1'b0;
        calc_invalid_c  = 1'b0;
        field_w_c       = NW_W'(26);
        unique case (s1_select_q)
            2'b01:   field_w_c = NW_W'(14);
            2'b10:   field_w_c = NW_W'(17);
            default: field_w_c = NW_W'(26);
        endcase
        // Bits [31:N-1] all equal means the value survives an N-bit round trip.
        shifted_c = VALUE_W'($signed(s1_value_q) >>> (field_w_c - NW_W'(1)));
        fits_c    = (shifted_c == '0) || (&shifted_c);
        mask_c    = (VALUE_W'(1) << field_w_c) - VALUE_W'(1);
        half_c    = VALUE_W'(1) << (field_w_c - NW_W'(1));
        if (s1_select_q == 2'b11) begin
            calc_invalid_c = 1'b1;
        end else begin
            calc_overflow_c = !fits_c;
            calc_field_c    = FIELD_W'(s1_value_q & mask_c);
`ifdef IMM_PACK_SATURATE_EN
            if (!fits_c) begin
                calc_field_c = s1_value_q[VALUE_W-1] ? FIELD_W'(half_c)
                                                     : FIELD_W'(half_c - VALUE_W'(1));
            end
`endif
        end
    end

    // Next-state for both stages and the error counters.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_value_d    = s1_value_q;
        s1_select_d   = s1_select_q;
        s2_valid_d    = s2_valid_q;
        s2_field_d    = s2_field_q;
        s2_select_d   = s2_select_q;
        s2_overflow_d = s2_overflow_q;
        s2_invalid_d  = s2_invalid_q;
        err_count_d   = err_count_q;
        err_sticky_d  = err_sticky_q;

        if (s1_adv_c) begin
            s1_valid_d = 1'b0;
        end
        if (in_fire_c) begin
            s1_valid_d  = 1'b1;
            s1_value_d  = bus.in_value;
            s1_select_d = bus.in_select;
        end

        if (out_fire_c) begin
            s2_valid_d = 1'b0;
        end
        if (s1_adv_c) begin
            s2_valid_d    = 1'b1;
            s2_field_d    = calc_field_c;
            s2_select_d   = s1_select_q;
            s2_overflow_d = calc_overflow_c;
            s2_invalid_d  = calc_invalid_c;
        end

        // A clear in the same cycle swallows the coinciding error.
        if (err_clear) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (out_fire_c && (s2_overflow_q || s2_invalid_q)) begin
            if (err_count_q != '1) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            err_sticky_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q    <= 1'b0;
            s1_value_q    <= '0;
            s1_select_q   <= '0;
            s2_valid_q    <= 1'b0;
            s2_field_q    <= '0;
            s2_select_q   <= '0;
            s2_overflow_q <= 1'b0;
            s2_invalid_q  <= 1'b0;
            err_count_q   <= '0;
            err_sticky_q  <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_value_q    <= s1_value_d;
            s1_select_q   <= s1_select_d;
            s2_valid_q    <= s2_valid_d;
            s2_field_q    <= s2_field_d;
            s2_select_q   <= s2_select_d;
            s2_overflow_q <= s2_overflow_d;
            s2_invalid_q  <= s2_invalid_d;
            err_count_q   <= err_count_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_field    = s2_field_q;
    assign bus.out_select   = s2_select_q;
    assign bus.out_overflow = s2_overflow_q;
    assign bus.out_invalid  = s2_invalid_q;
    assign err_count        = err_count_q;
    assign err_sticky       = err_sticky_q;
endmodule

// File: tb/tb_imm_field_packer.sv
// tb_imm_field_packer: directed and randomized checks of imm_field_packer
// against an arithmetic range/modulo reference model and a result queue.
module tb_imm_field_packer;
    typedef struct {
        logic [25:0] field;
        logic [1:0]  sel;
        logic        ovf;
        logic        inv;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        err_clear;
    logic [15:0] err_count;
    logic        err_sticky;

    int n_vec = 0;
    int n_err = 0;

    res_t        exp_q[$];
    logic [15:0] m_count;
    logic        m_sticky;

    logic        prev_stall = 1'b0;
    logic [25:0] prev_field;
    logic [1:0]  prev_sel;
    logic        prev_ovf;
    logic        prev_inv;

    imm_field_packer_if bus();

    imm_field_packer dut (
        .clock      (clk),
        .reset      (rst_n),
        .bus        (bus),
        .err_clear  (err_clear),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Reference: range test by signed comparison, field by modulo 2^N.
    function automatic res_t ref_pack(input logic [31:0] v, input logic [1:0] s);
        res_t   r;
        longint sv, lo, hi, span;
        int     n;
        r.sel = s; r.field = '0; r.ovf = 1'b0; r.inv = 1'b0;
        if (s == 2'b11) begin
            r.inv = 1'b1;
            return r;
        end
        n    = (s == 2'b00) ? 26 : (s == 2'b01) ? 14 : 17;
        sv   = longint'($signed(v));
        span = longint'(1) << n;
        hi   = span / 2 - 1;
        lo   = -(span / 2);
        r.ovf = (sv < lo) || (sv > hi);
`ifdef IMM_PACK_SATURATE_EN
        if (sv < lo) sv = lo;
        else if (sv > hi) sv = hi;
`endif
        r.field = 26'(((sv % span) + span) % span);
        return r;
    endfunction

    // Scoreboard: track accepts/deliveries and error counters every cycle.
    always @(negedge clk) begin
        res_t e;
        logic deliver_err;
        if (!rst_n) begin
            exp_q.delete();
            m_count    = '0;
            m_sticky   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            n_vec++;
            if (err_count !== m_count || err_sticky !== m_sticky) begin
                n_err++;
                $display("FAIL err_counters: got count=%h sticky=%b, expected count=%h sticky=%b",
                         err_count, err_sticky, m_count, m_sticky);
            end
            if (prev_stall) begin
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.out_field !== prev_field || bus.out_select !== prev_sel ||
                    bus.out_overflow !== prev_ovf || bus.out_invalid !== prev_inv) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b f=%h s=%b o=%b i=%b, expected v=1 f=%h s=%b o=%b i=%b",
                             bus.out_valid, bus.out_field, bus.out_select, bus.out_overflow, bus.out_invalid,
                             prev_field, prev_sel, prev_ovf, prev_inv);
                end
            end
            deliver_err = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got field=%h, expected no result", bus.out_field);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_field !== e.field || bus.out_select !== e.sel ||
                        bus.out_overflow !== e.ovf || bus.out_invalid !== e.inv) begin
                        n_err++;
                        $display("FAIL result: got f=%h s=%b o=%b i=%b, expected f=%h s=%b o=%b i=%b",
                                 bus.out_field, bus.out_select, bus.out_overflow, bus.out_invalid,
                                 e.field, e.sel, e.ovf, e.inv);
                    end
                    deliver_err = e.ovf || e.inv;
                end
            end
            if (err_clear) begin
                m_count  = '0;
                m_sticky = 1'b0;
            end else if (deliver_err) begin
                if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                m_sticky = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_pack(bus.in_value, bus.in_select));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_field = bus.out_field;
            prev_sel   = bus.out_select;
            prev_ovf   = bus.out_overflow;
            prev_inv   = bus.out_invalid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word for a single cycle (pipeline assumed able to accept).
    task automatic offer_one(input logic [31:0] v, input logic [1:0] s);
        bus.in_valid  = 1'b1;
        bus.in_value  = v;
        bus.in_select = s;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; err_clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_value = '0; bus.in_select = '0; bus.out_ready = 1'b1;
        tick(); tick(); tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_field !== 26'd0 || bus.out_select !== 2'd0 ||
            bus.out_overflow !== 1'b0 || bus.out_invalid !== 1'b0 || err_count !== 16'd0 || err_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b f=%h s=%b o=%b i=%b cnt=%h st=%b, expected all zero",
                     bus.out_valid, bus.out_field, bus.out_select, bus.out_overflow, bus.out_invalid, err_count, err_sticky);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end
    endtask

    task automatic test_range14();
        logic [25:0] exp_f;
        bus.out_ready = 1'b0;
        offer_one(32'hFFFFE000, 2'b01);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL lat14_early: got out_valid=%b, expected 0", bus.out_valid);
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== 26'h0002000 || bus.out_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL range14_min: got v=%b f=%h o=%b, expected v=1 f=0002000 o=0",
                     bus.out_valid, bus.out_field, bus.out_overflow);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
`ifdef IMM_PACK_SATURATE_EN
        exp_f = 26'h1FFF;
`else
        exp_f = 26'h2000;
`endif
        offer_one(32'h00002000, 2'b01);
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== exp_f || bus.out_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL range14_over: got v=%b f=%h o=%b, expected v=1 f=%h o=1",
                     bus.out_valid, bus.out_field, bus.out_overflow, exp_f);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_range26();
        logic [25:0] exp_f;
        bus.out_ready = 1'b0;
        offer_one(32'h01FFFFFF, 2'b00);
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== 26'h1FFFFFF || bus.out_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL range26_max: got v=%b f=%h o=%b, expected v=1 f=1ffffff o=0",
                     bus.out_valid, bus.out_field, bus.out_overflow);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
`ifdef IMM_PACK_SATURATE_EN
        exp_f = 26'h2000000;
`else
        exp_f = 26'h1FFFFFF;
`endif
        offer_one(32'hFDFFFFFF, 2'b00);
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== exp_f || bus.out_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL range26_under: got v=%b f=%h o=%b, expected v=1 f=%h o=1",
                     bus.out_valid, bus.out_field, bus.out_overflow, exp_f);
        end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_invalid();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        bus.out_ready = 1'b0;
        offer_one(32'h12345678, 2'b11);
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== 26'd0 || bus.out_invalid !== 1'b1 ||
            bus.out_overflow !== 1'b0 || err_count !== 16'd0) begin
            n_err++;
            $display("FAIL invalid_sel: got v=%b f=%h i=%b o=%b cnt=%h, expected v=1 f=0 i=1 o=0 cnt=0",
                     bus.out_valid, bus.out_field, bus.out_invalid, bus.out_overflow, err_count);
        end
        bus.out_ready = 1'b1;
        tick();
        n_vec++;
        if (err_count !== 16'd1 || err_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL invalid_count: got cnt=%h st=%b, expected cnt=0001 st=1", err_count, err_sticky);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w[4];
        logic [1:0]  s[4];
        int idx = 0;
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            s[i] = 2'($urandom_range(0, 2));
        end
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid  = (idx < 4);
            bus.in_value  = w[idx < 4 ? idx : 3];
            bus.in_select = s[idx < 4 ? idx : 3];
            #1;
            if (c >= 2) begin
                n_vec++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++; $display("FAIL bp_in_ready: got %b at cycle %0d, expected 0", bus.in_ready, c);
                end
            end
            if (bus.in_ready && idx < 4) idx++;
            tick();
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (idx != 2) begin
            n_err++; $display("FAIL bp_accepted: got %0d, expected 2", idx);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (bus.out_valid !== (c < 2)) begin
                n_err++; $display("FAIL bp_drain: got out_valid=%b at cycle %0d, expected %b", bus.out_valid, c, (c < 2));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_value  = $urandom;
            bus.in_select = 2'($urandom_range(0, 3));
            #1;
            n_vec++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_in_ready: got %b, expected 1", bus.in_ready);
            end
            tick();
            n_vec++;
            if (bus.out_valid !== (i >= 1)) begin
                n_err++; $display("FAIL b2b_valid: got %b after word %0d, expected %b", bus.out_valid, i, (i >= 1));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_tail: got %b, expected 1", bus.out_valid);
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_empty: got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int c = 0; c < 600; c++) begin
            v = $urandom;
            if ($urandom_range(0, 2) != 0) v = 32'($signed(v) >>> $urandom_range(6, 22));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_value  = v;
            bus.in_select = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            err_clear     = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; err_clear = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL random_drain: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_err_limits();
        bus.out_ready = 1'b1;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        bus.in_valid = 1'b1; bus.in_select = 2'b11; bus.in_value = 32'h0;
        for (int i = 0; i < 16'hFFFE; i++) tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (err_count !== 16'hFFFE || err_sticky !== 1'b1) begin
            n_err++; $display("FAIL err_preload: got cnt=%h st=%b, expected cnt=fffe st=1", err_count, err_sticky);
        end
        bus.in_valid = 1'b1;
        tick(); tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (err_count !== 16'hFFFF) begin
            n_err++; $display("FAIL err_saturate: got cnt=%h, expected ffff", err_count);
        end
        bus.out_ready = 1'b0;
        offer_one(32'h7FFFFFFF, 2'b01);
        tick();
        bus.out_ready = 1'b1;
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        n_vec++;
        if (err_count !== 16'd0 || err_sticky !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear_wins: got cnt=%h st=%b v=%b, expected cnt=0 st=0 v=0", err_count, err_sticky, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        offer_one(32'h0, 2'b11);
        tick();
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_select = 2'b10; bus.in_value = 32'h00012345;
        tick();
        bus.in_value = 32'hFFFF0001;
        tick();
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b0 || err_count !== 16'd1) begin
            n_err++; $display("FAIL mid_full: got in_ready=%b cnt=%h, expected in_ready=0 cnt=0001", bus.in_ready, err_count);
        end
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.out_field !== 26'd0 || err_count !== 16'd0 || err_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b f=%h cnt=%h st=%b, expected all zero", bus.out_valid, bus.out_field, err_count, err_sticky);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_in_ready: got %b, expected 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        offer_one(32'hFFFF0000, 2'b10);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_lat_early: got %b, expected 0", bus.out_valid);
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== 26'h0010000 || bus.out_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL mid_first_word: got v=%b f=%h o=%b, expected v=1 f=0010000 o=0", bus.out_valid, bus.out_field, bus.out_overflow);
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_range14();
        test_range26();
        test_invalid();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_err_limits();
        test_reset_mid();
        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
